// File: rtl/lc3b_types.sv
// Shared types for the mp3 memory-side arbiter: FSM encoding and grant identifiers.
package lc3b_types;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} lc3b_arb_state;

   localparam logic ARB_IFETCH = 1'b0;
   localparam logic ARB_DATA   = 1'b1;

endpackage

// File: rtl/wb_port_mux.sv
// Combinational request mux and response demux between two Wishbone masters and one slave.
module wb_port_mux
   import lc3b_types::*;
#(
   parameter int unsigned AddrW = 28,
   parameter int unsigned DataW = 128,
   parameter int unsigned SelW  = 16
) (
   input  logic             valid_i,
   input  logic             gnt_i,

   input  logic             i_cyc_i,
   input  logic             i_stb_i,
   input  logic             i_we_i,
   input  logic [AddrW-1:0] i_adr_i,
   input  logic [DataW-1:0] i_dat_m_i,
   input  logic [SelW-1:0]  i_sel_i,
   output logic [DataW-1:0] i_dat_s_o,
   output logic             i_ack_o,

   input  logic             d_cyc_i,
   input  logic             d_stb_i,
   input  logic             d_we_i,
   input  logic [AddrW-1:0] d_adr_i,
   input  logic [DataW-1:0] d_dat_m_i,
   input  logic [SelW-1:0]  d_sel_i,
   output logic [DataW-1:0] d_dat_s_o,
   output logic             d_ack_o,

   output logic             m_cyc_o,
   output logic             m_stb_o,
   output logic             m_we_o,
   output logic [AddrW-1:0] m_adr_o,
   output logic [DataW-1:0] m_dat_m_o,
   output logic [SelW-1:0]  m_sel_o,
   input  logic [DataW-1:0] m_dat_s_i,
   input  logic             m_ack_i
);

   // Everything idles at zero unless a grant is active; responses go only to the grantee.
   always_comb begin
      m_cyc_o   = 1'b0;
      m_stb_o   = 1'b0;
      m_we_o    = 1'b0;
      m_adr_o   = '0;
      m_dat_m_o = '0;
      m_sel_o   = '0;
      i_dat_s_o = '0;
      i_ack_o   = 1'b0;
      d_dat_s_o = '0;
      d_ack_o   = 1'b0;
      if (valid_i) begin
         if (gnt_i == ARB_DATA) begin
            m_cyc_o   = d_cyc_i;
            m_stb_o   = d_stb_i;
            m_we_o    = d_we_i;
            m_adr_o   = d_adr_i;
            m_dat_m_o = d_dat_m_i;
            m_sel_o   = d_sel_i;
            d_dat_s_o = m_dat_s_i;
            d_ack_o   = m_ack_i;
         end else begin
            m_cyc_o   = i_cyc_i;
            m_stb_o   = i_stb_i;
            m_we_o    = i_we_i;
            m_adr_o   = i_adr_i;
            m_dat_m_o = i_dat_m_i;
            m_sel_o   = i_sel_i;
            i_dat_s_o = m_dat_s_i;
            i_ack_o   = m_ack_i;
         end
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between the ifetch and data masters.
module wb_mem_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned SEL_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              i_cyc,
   input  logic              i_stb,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_adr,
   input  logic [DATA_W-1:0] i_dat_m,
   input  logic [SEL_W-1:0]  i_sel,
   output logic [DATA_W-1:0] i_dat_s,
   output logic              i_ack,

   input  logic              d_cyc,
   input  logic              d_stb,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_adr,
   input  logic [DATA_W-1:0] d_dat_m,
   input  logic [SEL_W-1:0]  d_sel,
   output logic [DATA_W-1:0] d_dat_s,
   output logic              d_ack,

   output logic              m_cyc,
   output logic              m_stb,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_adr,
   output logic [DATA_W-1:0] m_dat_m,
   output logic [SEL_W-1:0]  m_sel,
   input  logic [DATA_W-1:0] m_dat_s,
   input  logic              m_ack
);

   lc3b_arb_state state_q, state_d;
   logic          last_gnt_q, last_gnt_d;
   logic          i_req, d_req;
   logic          gnt_valid, gnt_sel;

   assign i_req     = i_cyc & i_stb;
   assign d_req     = d_cyc & d_stb;
   assign gnt_valid = (state_q != ARB_IDLE);
   assign gnt_sel   = (state_q == ARB_GNT_D) ? ARB_DATA : ARB_IFETCH;

   // An ack wins over a simultaneous cyc drop so the transfer still counts for round-robin.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (i_req && d_req) begin
               state_d = (last_gnt_q == ARB_DATA) ? ARB_GNT_I : ARB_GNT_D;
            end else if (i_req) begin
               state_d = ARB_GNT_I;
            end else if (d_req) begin
               state_d = ARB_GNT_D;
            end
         end
         ARB_GNT_I: begin
            if (m_ack) begin
               state_d    = ARB_IDLE;
               last_gnt_d = ARB_IFETCH;
            end else if (!i_cyc) begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GNT_D: begin
            if (m_ack) begin
               state_d    = ARB_IDLE;
               last_gnt_d = ARB_DATA;
            end else if (!d_cyc) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         last_gnt_q <= ARB_DATA;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   wb_port_mux #(
      .AddrW (ADDR_W),
      .DataW (DATA_W),
      .SelW  (SEL_W)
   ) u_port_mux (
      .valid_i   (gnt_valid),
      .gnt_i     (gnt_sel),
      .i_cyc_i   (i_cyc),
      .i_stb_i   (i_stb),
      .i_we_i    (i_we),
      .i_adr_i   (i_adr),
      .i_dat_m_i (i_dat_m),
      .i_sel_i   (i_sel),
      .i_dat_s_o (i_dat_s),
      .i_ack_o   (i_ack),
      .d_cyc_i   (d_cyc),
      .d_stb_i   (d_stb),
      .d_we_i    (d_we),
      .d_adr_i   (d_adr),
      .d_dat_m_i (d_dat_m),
      .d_sel_i   (d_sel),
      .d_dat_s_o (d_dat_s),
      .d_ack_o   (d_ack),
      .m_cyc_o   (m_cyc),
      .m_stb_o   (m_stb),
      .m_we_o    (m_we),
      .m_adr_o   (m_adr),
      .m_dat_m_o (m_dat_m),
      .m_sel_o   (m_sel),
      .m_dat_s_i (m_dat_s),
      .m_ack_i   (m_ack)
   );

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: vector table, per-master response scoreboards and corner cases.
module tb_wb_mem_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_cyc, i_stb, i_we;
   logic [27:0]   i_adr;
   logic [127:0]  i_dat_m;
   logic [15:0]   i_sel;
   logic [127:0]  i_dat_s;
   logic          i_ack;
   logic          d_cyc, d_stb, d_we;
   logic [27:0]   d_adr;
   logic [127:0]  d_dat_m;
   logic [15:0]   d_sel;
   logic [127:0]  d_dat_s;
   logic          d_ack;
   logic          m_cyc, m_stb, m_we;
   logic [27:0]   m_adr;
   logic [127:0]  m_dat_m;
   logic [15:0]   m_sel;
   logic [127:0]  m_dat_s;
   logic          m_ack;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic         mst;   // 0 = ifetch, 1 = data
      logic         we;
      logic [27:0]  adr;
      logic [15:0]  sel;
      logic [127:0] wdat;
      logic [127:0] rdat;
      int           lat;   // cycles from request to m_ack
   } vec_t;

   vec_t vecs[5];
   logic [127:0] sb_i[$];
   logic [127:0] sb_d[$];

   wb_mem_arbiter #(
      .ADDR_W (28),
      .DATA_W (128),
      .SEL_W  (16)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_cyc   (i_cyc),
      .i_stb   (i_stb),
      .i_we    (i_we),
      .i_adr   (i_adr),
      .i_dat_m (i_dat_m),
      .i_sel   (i_sel),
      .i_dat_s (i_dat_s),
      .i_ack   (i_ack),
      .d_cyc   (d_cyc),
      .d_stb   (d_stb),
      .d_we    (d_we),
      .d_adr   (d_adr),
      .d_dat_m (d_dat_m),
      .d_sel   (d_sel),
      .d_dat_s (d_dat_s),
      .d_ack   (d_ack),
      .m_cyc   (m_cyc),
      .m_stb   (m_stb),
      .m_we    (m_we),
      .m_adr   (m_adr),
      .m_dat_m (m_dat_m),
      .m_sel   (m_sel),
      .m_dat_s (m_dat_s),
      .m_ack   (m_ack)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] slv(input logic [27:0] a);
      return {4{4'h0, a}} ^ 128'h5a5a_1234_0f0f_abcd_c3c3_9876_a5a5_0102;
   endfunction

   task automatic clear_masters();
      i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_dat_m = '0; i_sel = '0;
      d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = '0; d_dat_m = '0; d_sel = '0;
   endtask

   task automatic drive_m(input logic mst, input logic we, input logic [27:0] adr,
                          input logic [15:0] sel, input logic [127:0] wdat);
      if (!mst) begin
         i_cyc = 1'b1; i_stb = 1'b1; i_we = we; i_adr = adr; i_sel = sel; i_dat_m = wdat;
      end else begin
         d_cyc = 1'b1; d_stb = 1'b1; d_we = we; d_adr = adr; d_sel = sel; d_dat_m = wdat;
      end
   endtask

   // Called in a cycle where master mst must see its ack; pops its expected read data.
   task automatic sb_ack(input logic mst);
      logic [127:0] exp;
      if (!mst) begin
         chk("ack_i", 128'(i_ack), 128'd1);
         chk("ack_d_quiet", 128'(d_ack), 128'd0);
         if (sb_i.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_i: ack with no expected response");
         end else begin
            exp = sb_i.pop_front();
            chk("dat_s_i", i_dat_s, exp);
         end
      end else begin
         chk("ack_d", 128'(d_ack), 128'd1);
         chk("ack_i_quiet", 128'(i_ack), 128'd0);
         if (sb_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_d: ack with no expected response");
         end else begin
            exp = sb_d.pop_front();
            chk("dat_s_d", d_dat_s, exp);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_masters();
      m_ack = 1'b0;
      m_dat_s = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Starts in a cycle where the DUT is IDLE; leaves the master requesting after its ack cycle.
   task automatic do_txn(input vec_t v);
      clear_masters();
      m_ack = 1'b0;
      m_dat_s = '0;
      drive_m(v.mst, v.we, v.adr, v.sel, v.wdat);
      if (!v.mst) sb_i.push_back(v.rdat);
      else        sb_d.push_back(v.rdat);
      @(negedge clk);
      chk("req_cycle_m_cyc", 128'(m_cyc), 128'd0);
      chk("req_cycle_i_ack", 128'(i_ack), 128'd0);
      chk("req_cycle_d_ack", 128'(d_ack), 128'd0);
      step();
      for (int k = 1; k <= v.lat; k++) begin
         if (k == v.lat) begin
            m_ack = 1'b1; m_dat_s = v.rdat;
         end else begin
            m_ack = 1'b0; m_dat_s = {4{$urandom}};
         end
         @(negedge clk);
         chk("gnt_m_cyc", 128'(m_cyc), 128'd1);
         chk("gnt_m_stb", 128'(m_stb), 128'd1);
         chk("gnt_m_adr", 128'(m_adr), 128'(v.adr));
         chk("gnt_m_we", 128'(m_we), 128'(v.we));
         chk("gnt_m_sel", 128'(m_sel), 128'(v.sel));
         chk("gnt_m_dat_m", m_dat_m, v.wdat);
         if (k == v.lat) begin
            sb_ack(v.mst);
         end else begin
            chk("wait_i_ack", 128'(i_ack), 128'd0);
            chk("wait_d_ack", 128'(d_ack), 128'd0);
         end
         step();
      end
      m_ack = 1'b0;
   endtask

   initial begin
      vec_t v;
      logic upd_i, upd_d;

      vecs[0] = '{mst: 1'b0, we: 1'b0, adr: 28'h0000010, sel: 16'hffff, wdat: '0,
                  rdat: 128'h0000_0000_0000_0000_0000_0000_0000_dead, lat: 3};
      vecs[1] = '{mst: 1'b1, we: 1'b1, adr: 28'h0000123, sel: 16'h00f0,
                  wdat: 128'h1111_2222_3333_4444_5555_6666_7777_8888, rdat: '0, lat: 2};
      vecs[2] = '{mst: 1'b1, we: 1'b0, adr: 28'h0000124, sel: 16'hffff, wdat: '0,
                  rdat: 128'hcafe_0000_0000_0000_0000_0000_0000_beef, lat: 1};
      vecs[3] = '{mst: 1'b1, we: 1'b0, adr: 28'h0000125, sel: 16'h0f0f, wdat: '0,
                  rdat: 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, lat: 1};
      vecs[4] = '{mst: 1'b0, we: 1'b1, adr: 28'hfffffff, sel: 16'hffff,
                  wdat: 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, rdat: '0, lat: 2};

      // Reset with both masters requesting: outputs must stay quiet.
      do_reset();
      rst_n = 1'b0;
      drive_m(1'b0, 1'b0, 28'h1, 16'hffff, '0);
      drive_m(1'b1, 1'b1, 28'h2, 16'hffff, '1);
      m_ack = 1'b1;
      @(negedge clk);
      chk("rst_m_cyc", 128'(m_cyc), 128'd0);
      chk("rst_m_adr", 128'(m_adr), 128'd0);
      chk("rst_i_ack", 128'(i_ack), 128'd0);
      chk("rst_d_ack", 128'(d_ack), 128'd0);
      step();
      do_reset();

      foreach (vecs[n]) do_txn(vecs[n]);
      clear_masters();
      step();

      // Simultaneous requests after reset: ifetch first, dead cycle, then the data write.
      do_reset();
      drive_m(1'b0, 1'b0, 28'h20, 16'hffff, '0);
      drive_m(1'b1, 1'b1, 28'h30, 16'h000f, 128'h00000000_00000000_00000000_aabbccdd);
      sb_i.push_back(slv(28'h20));
      sb_d.push_back(slv(28'h30));
      @(negedge clk);
      chk("tie_req_m_cyc", 128'(m_cyc), 128'd0);
      step();
      m_ack = 1'b1; m_dat_s = slv(28'h20);
      @(negedge clk);
      chk("tie_first_adr", 128'(m_adr), 128'h20);
      chk("tie_first_we", 128'(m_we), 128'd0);
      sb_ack(1'b0);
      step();
      i_cyc = 1'b0; i_stb = 1'b0; m_ack = 1'b0;
      @(negedge clk);
      chk("tie_dead_m_cyc", 128'(m_cyc), 128'd0);
      step();
      m_ack = 1'b1; m_dat_s = slv(28'h30);
      @(negedge clk);
      chk("tie_second_we", 128'(m_we), 128'd1);
      chk("tie_second_adr", 128'(m_adr), 128'h30);
      chk("tie_second_sel", 128'(m_sel), 128'h000f);
      chk("tie_second_dat_m", m_dat_m, 128'h00000000_00000000_00000000_aabbccdd);
      sb_ack(1'b1);
      step();
      clear_masters(); m_ack = 1'b0;
      @(negedge clk);
      chk("tie_end_m_cyc", 128'(m_cyc), 128'd0);
      step();

      // Continuous contention with a single-cycle-ack slave: strict I,D alternation.
      do_reset();
      drive_m(1'b0, 1'b0, 28'h100, 16'hffff, '0);
      drive_m(1'b1, 1'b0, 28'h200, 16'hffff, '0);
      sb_i.push_back(slv(28'h100));
      sb_d.push_back(slv(28'h200));
      for (int k = 0; k < 12; k++) begin
         upd_i = 1'b0; upd_d = 1'b0;
         #1;
         m_ack = m_cyc & m_stb;
         m_dat_s = slv(m_adr);
         @(negedge clk);
         chk("alt_m_cyc", 128'(m_cyc), 128'(k % 2));
         if (k % 2 == 1) begin
            if (((k - 1) / 2) % 2 == 0) begin
               sb_ack(1'b0); upd_i = 1'b1;
            end else begin
               sb_ack(1'b1); upd_d = 1'b1;
            end
         end else begin
            chk("alt_dead_i_ack", 128'(i_ack), 128'd0);
            chk("alt_dead_d_ack", 128'(d_ack), 128'd0);
         end
         step();
         if (upd_i) begin i_adr = i_adr + 28'd1; sb_i.push_back(slv(i_adr)); end
         if (upd_d) begin d_adr = d_adr + 28'd1; sb_d.push_back(slv(d_adr)); end
      end
      clear_masters(); m_ack = 1'b0;
      sb_i.delete(); sb_d.delete();
      step();

      // Abort by the data master, spurious late ack, and round-robin state left untouched.
      v = '{mst: 1'b0, we: 1'b0, adr: 28'h77, sel: 16'hffff, wdat: '0, rdat: slv(28'h77), lat: 1};
      do_txn(v);
      clear_masters();
      step();
      drive_m(1'b1, 1'b0, 28'h300, 16'hffff, '0);
      @(negedge clk);
      chk("abort_req_m_cyc", 128'(m_cyc), 128'd0);
      step();
      @(negedge clk);
      chk("abort_gnt_m_cyc", 128'(m_cyc), 128'd1);
      chk("abort_gnt_m_adr", 128'(m_adr), 128'h300);
      step();
      @(negedge clk);
      chk("abort_hold_m_cyc", 128'(m_cyc), 128'd1);
      step();
      d_cyc = 1'b0; d_stb = 1'b0;
      @(negedge clk);
      chk("abort_drop_m_cyc", 128'(m_cyc), 128'd0);
      chk("abort_drop_m_stb", 128'(m_stb), 128'd0);
      chk("abort_drop_d_ack", 128'(d_ack), 128'd0);
      step();
      m_ack = 1'b1; m_dat_s = '1;
      @(negedge clk);
      chk("late_ack_d_ack", 128'(d_ack), 128'd0);
      chk("late_ack_i_ack", 128'(i_ack), 128'd0);
      chk("late_ack_m_cyc", 128'(m_cyc), 128'd0);
      chk("late_ack_d_dat_s", d_dat_s, 128'd0);
      step();
      m_ack = 1'b0;
      drive_m(1'b0, 1'b0, 28'h400, 16'hffff, '0);
      drive_m(1'b1, 1'b0, 28'h500, 16'hffff, '0);
      sb_d.push_back(slv(28'h500));
      @(negedge clk);
      chk("post_abort_req_m_cyc", 128'(m_cyc), 128'd0);
      step();
      m_ack = 1'b1; m_dat_s = slv(28'h500);
      @(negedge clk);
      chk("post_abort_rr_adr", 128'(m_adr), 128'h500);
      sb_ack(1'b1);
      step();
      clear_masters(); m_ack = 1'b0;
      step();

      // Reset during a data grant with an ack still outstanding.
      v = '{mst: 1'b0, we: 1'b0, adr: 28'h88, sel: 16'hffff, wdat: '0, rdat: slv(28'h88), lat: 2};
      do_txn(v);
      clear_masters();
      step();
      drive_m(1'b1, 1'b0, 28'h600, 16'h00ff, '0);
      step();
      @(negedge clk);
      chk("rstmid_gnt_m_cyc", 128'(m_cyc), 128'd1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive_m(1'b0, 1'b0, 28'h700, 16'hffff, '0);
      sb_i.push_back(slv(28'h700));
      m_ack = 1'b1; m_dat_s = '1;
      @(negedge clk);
      chk("rstmid_m_cyc", 128'(m_cyc), 128'd0);
      chk("rstmid_m_stb", 128'(m_stb), 128'd0);
      chk("rstmid_m_adr", 128'(m_adr), 128'd0);
      chk("rstmid_m_sel", 128'(m_sel), 128'd0);
      chk("rstmid_d_ack", 128'(d_ack), 128'd0);
      chk("rstmid_i_ack", 128'(i_ack), 128'd0);
      chk("rstmid_d_dat_s", d_dat_s, 128'd0);
      chk("rstmid_i_dat_s", i_dat_s, 128'd0);
      step();
      m_ack = 1'b1; m_dat_s = slv(28'h700);
      @(negedge clk);
      chk("rstmid_tie_adr", 128'(m_adr), 128'h700);
      sb_ack(1'b0);
      step();
      clear_masters(); m_ack = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
